// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
//   Shared definitions for the interrupt controller: register word offsets,
//   FSM state encoding, CAUSE register layout and a helper that packs the
//   CAUSE word.
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

    // Register word offsets inside the block
    localparam logic [1:0] IRQ_EN    = 2'd0;
    localparam logic [1:0] IRQ_PEND  = 2'd1;
    localparam logic [1:0] IRQ_CAUSE = 2'd2;
    localparam logic [1:0] IRQ_EOI   = 2'd3;

    // Bit of CAUSE that reports "interrupt in service"
    localparam int CAUSE_ACT_BIT = 15;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Packs the CAUSE read word: active flag at CAUSE_ACT_BIT, index in [3:0]
    function automatic logic [15:0] cause_word(input logic act, input logic [3:0] idx);
        logic [15:0] w;
        w = 16'd0;
        w[3:0] = idx;
        w[CAUSE_ACT_BIT] = act;
        return w;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
//   Fixed-priority encoder: reports the lowest set index of req (bit 0 has the
//   highest priority) and whether any bit is set.
// Ports
//   req  in  N_IRQ  request vector
//   idx  out 4      lowest set index (0 when nothing is set)
//   any  out 1      at least one request bit set
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic [3:0]       idx,
    output logic             any
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx = 4'd0;
        any = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            idx = req[i] ? 4'(i) : idx;
            any = any | req[i];
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//   Interrupt controller: detects rising edges on up to 16 IRQ lines, latches
//   them as pending, masks with EN, picks the lowest pending enabled line and
//   issues a one-cycle int_vld pulse once the core reports int_rdy. The line
//   stays in service until software writes EOI.
//
// Configuration macro
//   IRQ_SYNC_EN : when defined, irq_in passes a 2-flop synchronizer before
//                 edge detection (+2 clk latency). Otherwise irq_in must be
//                 synchronous to clk.
//
// Ports
//   clk       in   1      system clock
//   rst       in   1      asynchronous reset, active-low
//   irq_in    in   N_IRQ  interrupt lines, rising edge = request
//   cfg_addr  in   2      register select (EN/PEND/CAUSE/EOI)
//   cfg_we    in   1      write strobe
//   cfg_din   in   16     write data
//   cfg_dout  out  16     read data, combinational from cfg_addr
//   int_vld   out  1      one-cycle interrupt pulse
//   int_rdy   in   1      core can accept an interrupt
//   irq_busy  out  1      interrupt in FIRE or SERVICE
// -----------------------------------------------------------------------------
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [1:0]       cfg_addr,
    input  logic             cfg_we,
    input  logic [15:0]      cfg_din,
    output logic [15:0]      cfg_dout,
    output logic             int_vld,
    input  logic             int_rdy,
    output logic             irq_busy
);

    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] irq_d_r;
    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] en_r;
    logic [N_IRQ-1:0] pend_r;
    logic [N_IRQ-1:0] req_s;
    logic [N_IRQ-1:0] w1c_s;
    logic [N_IRQ-1:0] fire_clr_s;
    logic [3:0]       sel_idx_s;
    logic             req_any_s;
    logic             fire_s;
    logic             eoi_wr_s;
    logic             cause_act_r;
    logic [3:0]       cause_idx_r;
    logic             int_vld_r;
    logic             irq_busy_r;
    irq_state_e       state_r;
    logic             cfg_din_unused_s;

    // Write data bits at or above N_IRQ are architecturally ignored
    assign cfg_din_unused_s = ^cfg_din;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_r;
    logic [N_IRQ-1:0] sync2_r;

    // Two-flop synchronizer for asynchronous IRQ pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= {N_IRQ{1'b0}};
            sync2_r <= {N_IRQ{1'b0}};
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
        end
    end

    assign irq_s = sync2_r;
`else
    assign irq_s = irq_in;
`endif

    assign rise_s   = irq_s & ~irq_d_r;
    assign req_s    = pend_r & en_r;
    assign eoi_wr_s = cfg_we && (cfg_addr == IRQ_EOI);
    assign fire_s   = (state_r == IDLE) && req_any_s && int_rdy;

    irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .req (req_s),
        .idx (sel_idx_s),
        .any (req_any_s)
    );

    // Software write-1-to-clear mask for PEND
    always_comb begin
        w1c_s = {N_IRQ{1'b0}};
        if (cfg_we && (cfg_addr == IRQ_PEND)) begin
            w1c_s = cfg_din[N_IRQ-1:0];
        end else begin
            w1c_s = {N_IRQ{1'b0}};
        end
    end

    // One-hot clear of the line being taken into service
    always_comb begin
        fire_clr_s = {N_IRQ{1'b0}};
        for (int i = 0; i < N_IRQ; i++) begin
            fire_clr_s[i] = fire_s && (sel_idx_s == 4'(i));
        end
    end

    // Edge history, enable and pending registers; a new edge beats any clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d_r <= {N_IRQ{1'b0}};
            en_r    <= {N_IRQ{1'b0}};
            pend_r  <= {N_IRQ{1'b0}};
        end else begin
            irq_d_r <= irq_s;
            if (cfg_we && (cfg_addr == IRQ_EN)) begin
                en_r <= cfg_din[N_IRQ-1:0];
            end
            pend_r <= (pend_r & ~w1c_s & ~fire_clr_s) | rise_s;
        end
    end

    // Service FSM with registered pulse, busy and CAUSE outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            int_vld_r   <= 1'b0;
            irq_busy_r  <= 1'b0;
            cause_act_r <= 1'b0;
            cause_idx_r <= 4'd0;
        end else begin
            int_vld_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fire_s) begin
                        state_r     <= FIRE;
                        irq_busy_r  <= 1'b1;
                        cause_act_r <= 1'b1;
                        cause_idx_r <= sel_idx_s;
                    end
                end
                FIRE: begin
                    // EOI is ignored here; the pulse is issued exactly once
                    state_r   <= SERVICE;
                    int_vld_r <= 1'b1;
                end
                SERVICE: begin
                    if (eoi_wr_s) begin
                        state_r     <= IDLE;
                        irq_busy_r  <= 1'b0;
                        cause_act_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    irq_busy_r  <= 1'b0;
                    cause_act_r <= 1'b0;
                end
            endcase
        end
    end

    // Register read mux; unimplemented bits read as zero
    always_comb begin
        cfg_dout = 16'd0;
        case (cfg_addr)
            IRQ_EN:    cfg_dout = 16'(en_r);
            IRQ_PEND:  cfg_dout = 16'(pend_r);
            IRQ_CAUSE: cfg_dout = cause_word(cause_act_r, cause_idx_r);
            IRQ_EOI:   cfg_dout = 16'd0;
            default:   cfg_dout = 16'd0;
        endcase
    end

    assign int_vld  = int_vld_r;
    assign irq_busy = irq_busy_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
//   Directed and randomized checks of irq_ctrl (N_IRQ=8) against a reference
//   model that works per clock edge from the controller's rules: pending set
//   on edges, lowest enabled pending line taken when the core is ready, pulse
//   one edge after the take, EOI honoured from the second edge after the take.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam logic [15:0] MASK = 16'h00FF;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_in;
    logic [1:0]  cfg_addr;
    logic        cfg_we;
    logic [15:0] cfg_din;
    logic [15:0] cfg_dout;
    logic        int_vld;
    logic        int_rdy;
    logic        irq_busy;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int edge_n = 0;

    // Reference model state
    logic [15:0] m_en, m_pend, m_prev, m_sy1, m_sy2;
    bit          m_serving;
    logic [3:0]  m_idx;
    int          m_take_edge;
    bit          exp_vld;

    irq_ctrl #(.N_IRQ(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .cfg_addr (cfg_addr),
        .cfg_we   (cfg_we),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout),
        .int_vld  (int_vld),
        .int_rdy  (int_rdy),
        .irq_busy (irq_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_en = 16'd0; m_pend = 16'd0; m_prev = 16'd0; m_sy1 = 16'd0; m_sy2 = 16'd0;
        m_serving = 1'b0; m_idx = 4'd0; m_take_edge = -100; exp_vld = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_edge();
        logic [15:0] seen, rises, req;
        seen  = (SYNC_LAT == 2) ? m_sy2 : 16'(irq_in);
        rises = seen & ~m_prev;
        m_prev = seen;
        m_sy2  = m_sy1;
        m_sy1  = 16'(irq_in);
        req = m_pend & m_en;
        if (!m_serving && req != 16'd0 && int_rdy) begin
            m_idx = lowest(req);
            m_serving = 1'b1;
            m_take_edge = edge_n;
            m_pend[m_idx] = 1'b0;
        end else if (m_serving && cfg_we && cfg_addr == 2'd3 && edge_n >= m_take_edge + 2) begin
            m_serving = 1'b0;
        end
        if (cfg_we && cfg_addr == 2'd1) m_pend = m_pend & ~(cfg_din & MASK);
        if (cfg_we && cfg_addr == 2'd0) m_en = cfg_din & MASK;
        m_pend = m_pend | rises;
        exp_vld = m_serving && (edge_n == m_take_edge + 1);
    endtask

    task automatic step();
        model_edge();
        edge_n++;
        @(posedge clk);
        #1;
        chk("int_vld", {15'd0, int_vld}, {15'd0, exp_vld});
        chk("irq_busy", {15'd0, irq_busy}, {15'd0, m_serving});
        if (int_vld) pulses++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_addr = a; cfg_din = d; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1;
        d = cfg_dout;
    endtask

    task automatic check_regs();
        logic [15:0] d;
        rd(2'd0, d); chk("EN", d, m_en);
        rd(2'd1, d); chk("PEND", d, m_pend);
        rd(2'd2, d); chk("CAUSE", d, {m_serving, 11'd0, m_idx});
        rd(2'd3, d); chk("EOI_rd", d, 16'd0);
    endtask

    task automatic mid_reset();
        rst = 1'b0; irq_in = 8'd0; cfg_we = 1'b0;
        #1;
        chk("rst_vld", {15'd0, int_vld}, 16'd0);
        chk("rst_busy", {15'd0, irq_busy}, 16'd0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_hold_vld", {15'd0, int_vld}, 16'd0);
        rst = 1'b1;
        check_regs();
    endtask

    initial begin : main
        logic [15:0] d;
        int n, p0;

        rst = 1'b0; irq_in = 8'd0; cfg_addr = 2'd0; cfg_we = 1'b0; cfg_din = 16'd0; int_rdy = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_vld", {15'd0, int_vld}, 16'd0);
        chk("reset_busy", {15'd0, irq_busy}, 16'd0);
        check_regs();

        // Single line: EN=0x04, pulse irq_in[2]
        wr(2'd0, 16'h0004);
        irq_in = 8'h04; step(); repeat (SYNC_LAT) step();
        irq_in = 8'h00;
        rd(2'd1, d); chk("t1_pend_set", d, 16'h0004);
        step();
        step();
        chk("t1_vld", {15'd0, int_vld}, 16'd1);
        rd(2'd2, d); chk("t1_cause", d, 16'h8002);
        rd(2'd1, d); chk("t1_pend_clr", d, 16'h0000);
        step();
        chk("t1_vld_1cyc", {15'd0, int_vld}, 16'd0);
        wr(2'd3, 16'h1234);
        rd(2'd2, d); chk("t1_cause_eoi", d, 16'h0002);
        chk("t1_busy_eoi", {15'd0, irq_busy}, 16'd0);

        // Two lines same cycle: idx1 before idx5, two pulses total
        wr(2'd0, 16'h00FF);
        p0 = pulses;
        irq_in = 8'h22; step(); repeat (SYNC_LAT) step();
        irq_in = 8'h00;
        n = 0;
        while (!int_vld && n < 10) begin step(); n++; end
        chk("t2_first_seen", {15'd0, int_vld}, 16'd1);
        rd(2'd2, d); chk("t2_cause1", d, 16'h8001);
        wr(2'd3, 16'h0000);
        n = 0;
        while (!int_vld && n < 10) begin step(); n++; end
        chk("t2_second_seen", {15'd0, int_vld}, 16'd1);
        rd(2'd2, d); chk("t2_cause5", d, 16'h8005);
        wr(2'd3, 16'h0000);
        repeat (6) step();
        chk("t2_pulse_count", 16'(pulses - p0), 16'd2);

        // Core not ready for 10 cycles, then ready: pulse 2 cycles later
        int_rdy = 1'b0;
        irq_in = 8'h01; step(); repeat (SYNC_LAT) step();
        irq_in = 8'h00;
        p0 = pulses;
        repeat (10) step();
        chk("t3_no_pulse", 16'(pulses - p0), 16'd0);
        int_rdy = 1'b1;
        step();
        chk("t3_vld_c1", {15'd0, int_vld}, 16'd0);
        step();
        chk("t3_vld_c2", {15'd0, int_vld}, 16'd1);
        step();
        wr(2'd3, 16'h0000);

        // W1C on the same cycle as a rising edge: set wins
        wr(2'd0, 16'h0000);
        irq_in = 8'h08; repeat (SYNC_LAT) step();
        wr(2'd1, 16'h0008);
        rd(2'd1, d); chk("t4_set_wins", d, 16'h0008);
        wr(2'd1, 16'h0008);
        rd(2'd1, d); chk("t4_w1c", d, 16'h0000);
        irq_in = 8'h00; step();

        // Reset while in service
        wr(2'd0, 16'h0001);
        irq_in = 8'h01; step(); repeat (SYNC_LAT) step();
        irq_in = 8'h00;
        step(); step();
        chk("t5_busy_before", {15'd0, irq_busy}, 16'd1);
        mid_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (c == 300) mid_reset();
            check_regs();
            if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
            int_rdy = ($urandom_range(0, 3) != 0);
            cfg_we = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                cfg_addr = 2'($urandom);
                cfg_din  = 16'($urandom);
                cfg_we   = 1'b1;
            end
            step();
            cfg_we = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
